// File: rtl/extbus_pkg.sv
// Shared types and helpers for the external bus controller: FSM state encoding,
// access-phase length bounds and the cartridge/SRAM chip-select decode.
package extbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } extbus_state_e;

    localparam int EXTBUS_WAIT_MIN = 1;
    localparam int EXTBUS_WAIT_MAX = 15;

    // 0x8000-0x9FFF and 0xC000-0xDFFF select the external SRAM (cs = 0).
    function automatic logic extbus_cs_decode(input logic [15:0] addr);
        return ~(addr[15] & ~addr[13]);
    endfunction

endpackage

// File: rtl/extbus_arb_pick.sv
// Combinational grant selection between the core port (0) and loader port (1).
// EXTBUS_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module extbus_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_port,
    output logic grant_valid,
    output logic grant_port
);

`ifdef EXTBUS_RR_EN
    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = 1'b0;
        if (req0 && req1) begin
            grant_port = ~last_port;
        end else begin
            grant_port = req1;
        end
    end
`else
    logic unused_last_port;
    assign unused_last_port = last_port;

    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = ~req0 & req1;
    end
`endif

endmodule

// File: rtl/extbus_ctrl.sv
// External bus controller: arbitrates two requesters onto the shared cartridge/SRAM
// bus as ADDR -> ACCESS (WAIT_CYCLES) -> DONE. Optional macro: EXTBUS_RR_EN.
module extbus_ctrl
    import extbus_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        ack0,
    output logic        ack1,
    output logic [7:0]  rdata,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        bus_doe,
    output logic        bus_wr,
    output logic        bus_cale,
    output logic        bus_cs
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    extbus_state_e state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          port_q, port_d;
    logic          last_q, last_d;

    logic [15:0]   bus_a_q, bus_a_d;
    logic [7:0]    bus_dout_q, bus_dout_d;
    logic          bus_doe_q, bus_doe_d;
    logic          bus_wr_q, bus_wr_d;
    logic          bus_cale_q, bus_cale_d;
    logic          bus_cs_q, bus_cs_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [7:0]    rdata_q, rdata_d;

    logic          grant_valid;
    logic          grant_port;
    logic [15:0]   sel_addr;
    logic [7:0]    sel_wdata;
    logic          sel_we;

    extbus_arb_pick u_arb (
        .req0        (req0),
        .req1        (req1),
        .last_port   (last_q),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    assign sel_addr  = grant_port ? addr1  : addr0;
    assign sel_wdata = grant_port ? wdata1 : wdata0;
    assign sel_we    = grant_port ? we1    : we0;

    // Bus outputs are computed one cycle ahead so every pin comes straight off a flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        port_d     = port_q;
        last_d     = last_q;
        bus_a_d    = bus_a_q;
        bus_dout_d = bus_dout_q;
        bus_doe_d  = bus_doe_q;
        bus_cs_d   = bus_cs_q;
        bus_wr_d   = 1'b0;
        bus_cale_d = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata_d    = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d    = ST_ADDR;
                    port_d     = grant_port;
                    last_d     = grant_port;
                    we_d       = sel_we;
                    bus_a_d    = sel_addr;
                    bus_dout_d = sel_wdata;
                    bus_doe_d  = sel_we;
                    bus_cs_d   = extbus_cs_decode(sel_addr);
                    bus_cale_d = 1'b1;
                end
            end
            ST_ADDR: begin
                state_d  = ST_ACCESS;
                cnt_d    = WAIT_LOAD;
                bus_wr_d = we_q;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd1) begin
                    state_d   = ST_DONE;
                    cnt_d     = 4'd0;
                    bus_doe_d = 1'b0;
                    ack0_d    = ~port_q;
                    ack1_d    = port_q;
                    if (!we_q) begin
                        rdata_d = bus_din;
                    end
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    bus_wr_d = we_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset aborts any access in flight without acknowledging it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            port_q     <= 1'b0;
            last_q     <= 1'b1;
            bus_a_q    <= 16'h0000;
            bus_dout_q <= 8'h00;
            bus_doe_q  <= 1'b0;
            bus_wr_q   <= 1'b0;
            bus_cale_q <= 1'b0;
            bus_cs_q   <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            port_q     <= port_d;
            last_q     <= last_d;
            bus_a_q    <= bus_a_d;
            bus_dout_q <= bus_dout_d;
            bus_doe_q  <= bus_doe_d;
            bus_wr_q   <= bus_wr_d;
            bus_cale_q <= bus_cale_d;
            bus_cs_q   <= bus_cs_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata    = rdata_q;
    assign bus_a    = bus_a_q;
    assign bus_dout = bus_dout_q;
    assign bus_doe  = bus_doe_q;
    assign bus_wr   = bus_wr_q;
    assign bus_cale = bus_cale_q;
    assign bus_cs   = bus_cs_q;

endmodule
